// File: rtl/exu_div_radix2_if.sv
// Divide request/response bundle between the EXU operand muxes (master)
// and the radix-2 divider (slave).
interface exu_div_radix2_if #(
  parameter int WIDTH = 32
);
  logic             valid_in;
  logic             unsign;
  logic             rem;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             flush;
  logic [WIDTH-1:0] result;
  logic             finish;
  logic             stall;

  modport master (
    output valid_in, unsign, rem, dividend, divisor, flush,
    input  result, finish, stall
  );

  modport slave (
    input  valid_in, unsign, rem, dividend, divisor, flush,
    output result, finish, stall
  );
endinterface

// File: rtl/exu_div_radix2.sv
// Iterative radix-2 restoring divider with RV32M semantics. One quotient bit
// is produced per cycle; divide-by-zero and signed overflow bypass the loop.
module exu_div_radix2 #(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  exu_div_radix2_if.slave  div_if
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ITER,
    FIX,
    DONE
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] dividend_q;
  logic [WIDTH-1:0] divisor_q;
  logic             unsign_q;
  logic             rem_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  // The stored remainder never exceeds the divisor, so its top (WIDTH+1)th
  // bit is always zero after a step; only the shifted working value is wide.
  logic [WIDTH-1:0] r_q;
  logic             sign_q;
  logic             sign_r;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] result_q;

  logic             signed_op;
  logic             div_zero;
  logic             overflow;
  logic             special;
  logic             accept;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   r_sub;
  logic             r_ge;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] result_next;

  assign signed_op = ~unsign_q;
  assign div_zero  = (divisor_q == '0);
  assign overflow  = signed_op && (dividend_q == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor_q == '1);
  assign special   = div_zero | overflow;
  assign accept    = (state == IDLE) && div_if.valid_in && !div_if.flush;

  assign r_shift = {r_q, a_q[WIDTH-1]};
  assign r_ge    = (r_shift >= {1'b0, b_q});
  assign r_sub   = r_shift - {1'b0, b_q};

  assign q_fix   = (signed_op && sign_q) ? -a_q : a_q;
  assign rem_fix = (signed_op && sign_r) ? -r_q : r_q;

  // State register; reset drops any in-flight operation without a finish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state sequencing; flush overrides everything outside IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SETUP;
      SETUP:   state_next = special ? DONE : ITER;
      ITER:    if (count_q == CNT_W'(WIDTH-1)) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (div_if.flush && (state != IDLE)) state_next = IDLE;
  end

  // Value loaded into result on the edge that enters DONE.
  always_comb begin
    result_next = result_q;
    if (state == SETUP) begin
      if (div_zero) result_next = rem_q ? dividend_q : '1;
      else          result_next = rem_q ? '0 : dividend_q;
    end else if (state == FIX) begin
      result_next = rem_q ? rem_fix : q_fix;
    end
  end

  // Operand capture, magnitude setup and the shift/subtract iteration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dividend_q <= '0;
      divisor_q  <= '0;
      unsign_q   <= 1'b0;
      rem_q      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      r_q        <= '0;
      sign_q     <= 1'b0;
      sign_r     <= 1'b0;
      count_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dividend_q <= div_if.dividend;
            divisor_q  <= div_if.divisor;
            unsign_q   <= div_if.unsign;
            rem_q      <= div_if.rem;
          end
        end
        SETUP: begin
          a_q     <= (signed_op && dividend_q[WIDTH-1]) ? -dividend_q : dividend_q;
          b_q     <= (signed_op && divisor_q[WIDTH-1])  ? -divisor_q  : divisor_q;
          sign_q  <= dividend_q[WIDTH-1] ^ divisor_q[WIDTH-1];
          sign_r  <= dividend_q[WIDTH-1];
          r_q     <= '0;
          count_q <= '0;
        end
        ITER: begin
          count_q <= count_q + CNT_W'(1);
          if (r_ge) begin
            r_q <= r_sub[WIDTH-1:0];
            a_q <= {a_q[WIDTH-2:0], 1'b1};
          end else begin
            r_q <= r_shift[WIDTH-1:0];
            a_q <= {a_q[WIDTH-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  // Result register changes only when DONE is entered, so flushes leave it intact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     result_q <= '0;
    else if (state_next == DONE) result_q <= result_next;
  end

  assign div_if.result = result_q;
  assign div_if.finish = (state == DONE);
  assign div_if.stall  = (state == SETUP) || (state == ITER) || (state == FIX);

endmodule
